bitcoin_job_controller: RTL
===========================

// Module: bitcoin_job_controller
// PURPOSE
//  Host-side initiator for the bitcoin_hash core: writes a 19-word block header into shared memory and pulses start.
//  It then waits for done and reads back the NUM_NONCE H0 results.
//  It reports the smallest H0 (golden-nonce candidate) and whether it is below a target.
//  It sits between the job source and the shared single-port synchronous memory, and owns that memory except while the hasher runs.
// PARAMETERS
//  NUM_NONCE       16       results read back, one per nonce 0..NUM_NONCE-1
//  MSG_WORDS       19       header words written per job
//  MSG_BASE        16'h0000 memory base of header; also driven on message_addr
//  OUT_BASE        16'h0100 memory base of results; also driven on output_addr
//  TIMEOUT_CYCLES  4096     maximum WAIT cycles before the job is aborted
// PORTS
//  clk            in   1   clock
//  reset_n        in   1   synchronous active-low reset
//  job_valid      in   1   job_word valid
//  job_ready      out  1   controller accepts a word (comb: state IDLE or LOAD)
//  job_word       in   32  header word, in order 0..MSG_WORDS-1
//  target         in   32  difficulty target, sampled with header word 0
//  mem_sel        out  1   1 = controller drives memory port, 0 = hasher drives it
//  mem_we         out  1   memory write enable
//  mem_addr       out  16  memory address
//  mem_write_data out  32  memory write data
//  mem_read_data  in   32  memory read data, valid 1 cycle after address
//  message_addr   out  16  constant MSG_BASE to hasher
//  output_addr    out  16  constant OUT_BASE to hasher
//  hash_start     out  1   one-cycle start pulse to hasher
//  hash_done      in   1   hasher completion pulse (1 cycle)
//  res_valid      out  1   result valid, held until res_ready
//  res_ready      in   1   result consumer ready
//  res_found      out  1   res_hash < target
//  res_nonce      out  $clog2(NUM_NONCE)  nonce of minimum H0
//  res_hash       out  32  minimum H0
//  res_timeout    out  1   hasher did not finish in time
// BEHAVIOUR
//  Reset values:
//   - state IDLE; mem_sel=1; mem_we=0; mem_addr=0; mem_write_data=0.
//   - hash_start=0; res_*=0; counters 0.
//   - Reset mid-job aborts immediately; memory contents are not restored.
//  IDLE/LOAD (accepting job words):
//   - A word transfers on job_valid&&job_ready. Word 0 moves IDLE->LOAD and latches target.
//   - A word accepted in cycle N is driven in cycle N+1: mem_we=1, mem_addr=MSG_BASE+idx, mem_write_data=word. Otherwise mem_we=0.
//   - Gaps in job_valid are allowed.
//   - The MSG_WORDS-th transfer moves the FSM to START.
//  START:
//   - hash_start=1 for exactly one cycle; mem_sel=0 from this cycle.
//   - Next state is WAIT.
//  WAIT:
//   - mem_sel=0; the watchdog counts.
//   - hash_done=1 moves the FSM to READ, mem_sel=1.
//   - The watchdog reaching TIMEOUT_CYCLES-1 without done moves the FSM to REPORT with:
//     res_timeout=1, res_found=0, res_nonce=0, res_hash=32'hFFFFFFFF.
//   - hash_done seen outside WAIT is ignored.
//  READ:
//   - Issue cycles r=0..NUM_NONCE-1: mem_we=0, mem_addr=OUT_BASE+r.
//   - The data for r is captured in cycle r+1 and compared unsigned against the running minimum (initialised to 32'hFFFFFFFF, nonce 0).
//   - A strictly-less comparison updates the minimum, so on ties the lowest nonce wins.
//   - The cycle after capture of r=NUM_NONCE-1, the FSM goes to REPORT.
//   - Total READ latency: NUM_NONCE+1 cycles.
//  REPORT:
//   - res_valid=1; res_found = (min < target), strictly less.
//   - res_* stay stable while res_valid&&!res_ready.
//   - Handshake completion moves the FSM to IDLE next cycle with res_valid=0.
//   - Simultaneous job_valid is not accepted (job_ready=0).
//  Widths:
//   - Address arithmetic is 16-bit wrapping.
//   - Watchdog width is $clog2(TIMEOUT_CYCLES)+1.
// STRUCTURE
//  bitcoin_pkg: state enum {IDLE,LOAD,START,WAIT,READ,REPORT}, NUM_NONCE, MSG_WORDS, default base addresses.
//  Sub-module golden_nonce_tracker: clear/valid/data/index in, min hash + index out.
//  The FSM, counters and memory port registers live in this module.
// TESTING
//  1. Header 32'h1000_0000+i, model H0[n]=32'h9000_0000-n, target 32'h0000_1000:
//     writes at 0x0000..0x0012, one start pulse, reads 0x0100..0x010F.
//     Expect res_found=0, res_nonce=15, res_hash=32'h8FFF_FFF1.
//  2. H0[5]=H0[9]=32'h0000_0FFF, others 32'hFFFF_0000, target 32'h0000_1000:
//     expect res_found=1, res_nonce=5, res_hash=32'h0000_0FFF.
//  3. H0[3]=32'h0000_1000 minimum, target 32'h0000_1000:
//     expect res_found=0, res_nonce=3.
//  4. Hasher model never pulses done:
//     expect res_valid exactly TIMEOUT_CYCLES cycles after hash_start, res_timeout=1, res_hash=32'hFFFFFFFF.
//  5. job_valid toggled randomly, res_ready low 10 cycles:
//     - write addresses stay in order with no gaps in index;
//     - res_* remain stable;
//     - job_ready=0 until handshake.
//  6. reset_n low 1 cycle during WAIT:
//     - next cycle state IDLE, mem_sel=1, hash_start=0, res_valid=0;
//     - a following full job completes correctly.

Source files
------------

// File: rtl/bitcoin_pkg.sv
// Shared types and default geometry for the bitcoin job controller slice.
package bitcoin_pkg;

    localparam int          NUM_NONCE_DEF      = 16;
    localparam int          MSG_WORDS_DEF      = 19;
    localparam logic [15:0] MSG_BASE_DEF       = 16'h0000;
    localparam logic [15:0] OUT_BASE_DEF       = 16'h0100;
    localparam int          TIMEOUT_CYCLES_DEF = 4096;
    localparam logic [31:0] HASH_MAX           = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        READ,
        REPORT
    } job_state_t;

endpackage

// File: rtl/bitcoin_job_controller_golden_nonce_tracker.sv
// Running unsigned minimum over a stream of indexed H0 words; ties keep the earlier index.
// o_min_* already include the word presented this cycle so the final capture can be registered directly.
module golden_nonce_tracker
    import bitcoin_pkg::*;
#(
    parameter int IDX_W = 4
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [31:0]      i_data,
    input  logic [IDX_W-1:0] i_index,
    output logic [31:0]      o_min_hash,
    output logic [IDX_W-1:0] o_min_index
);

    logic [31:0]      r_min_hash;
    logic [IDX_W-1:0] r_min_index;
    logic             w_take;

    assign w_take      = i_valid && (i_data < r_min_hash);
    assign o_min_hash  = w_take ? i_data  : r_min_hash;
    assign o_min_index = w_take ? i_index : r_min_index;

    always_ff @(posedge clk) begin
        if (!reset_n || i_clear) begin
            r_min_hash  <= HASH_MAX;
            r_min_index <= '0;
        end else begin
            r_min_hash  <= o_min_hash;
            r_min_index <= o_min_index;
        end
    end

endmodule

// File: rtl/bitcoin_job_controller.sv
// Host-side job sequencer for bitcoin_hash: loads the header, starts the hasher, scans the
// H0 results for the golden-nonce candidate and reports it against the latched target.
module bitcoin_job_controller
    import bitcoin_pkg::*;
#(
    parameter int          NUM_NONCE      = NUM_NONCE_DEF,
    parameter int          MSG_WORDS      = MSG_WORDS_DEF,
    parameter logic [15:0] MSG_BASE       = MSG_BASE_DEF,
    parameter logic [15:0] OUT_BASE       = OUT_BASE_DEF,
    parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    localparam int         IDX_W          = $clog2(NUM_NONCE),
    localparam int         WD_W           = $clog2(TIMEOUT_CYCLES) + 1,
    localparam int         WIDX_W         = $clog2(MSG_WORDS) + 1
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_job_valid,
    output logic             o_job_ready,
    input  logic [31:0]      i_job_word,
    input  logic [31:0]      i_target,
    output logic             o_mem_sel,
    output logic             o_mem_we,
    output logic [15:0]      o_mem_addr,
    output logic [31:0]      o_mem_write_data,
    input  logic [31:0]      i_mem_read_data,
    output logic [15:0]      o_message_addr,
    output logic [15:0]      o_output_addr,
    output logic             o_hash_start,
    input  logic             i_hash_done,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic             o_res_found,
    output logic [IDX_W-1:0] o_res_nonce,
    output logic [31:0]      o_res_hash,
    output logic             o_res_timeout
);

    job_state_t        r_state;
    logic [WIDX_W-1:0] r_word_idx;
    logic [WD_W-1:0]   r_wd;
    logic [IDX_W:0]    r_rd_idx;
    logic              r_cap_valid;
    logic [IDX_W-1:0]  r_cap_idx;
    logic [31:0]       r_target;

    logic              r_mem_sel;
    logic              r_mem_we;
    logic [15:0]       r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_hash_start;
    logic              r_res_valid;
    logic              r_res_found;
    logic [IDX_W-1:0]  r_res_nonce;
    logic [31:0]       r_res_hash;
    logic              r_res_timeout;

    logic              w_accept;
    logic              w_trk_clear;
    logic [31:0]       w_min_hash;
    logic [IDX_W-1:0]  w_min_index;

    assign o_job_ready      = (r_state == IDLE) || (r_state == LOAD);
    assign w_accept         = i_job_valid && o_job_ready;
    assign w_trk_clear      = (r_state == WAIT) && i_hash_done;

    assign o_message_addr   = MSG_BASE;
    assign o_output_addr    = OUT_BASE;
    assign o_mem_sel        = r_mem_sel;
    assign o_mem_we         = r_mem_we;
    assign o_mem_addr       = r_mem_addr;
    assign o_mem_write_data = r_mem_wdata;
    assign o_hash_start     = r_hash_start;
    assign o_res_valid      = r_res_valid;
    assign o_res_found      = r_res_found;
    assign o_res_nonce      = r_res_nonce;
    assign o_res_hash       = r_res_hash;
    assign o_res_timeout    = r_res_timeout;

    golden_nonce_tracker #(
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (w_trk_clear),
        .i_valid     (r_cap_valid),
        .i_data      (i_mem_read_data),
        .i_index     (r_cap_idx),
        .o_min_hash  (w_min_hash),
        .o_min_index (w_min_index)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_word_idx    <= '0;
            r_wd          <= '0;
            r_rd_idx      <= '0;
            r_cap_valid   <= 1'b0;
            r_cap_idx     <= '0;
            r_target      <= '0;
            r_mem_sel     <= 1'b1;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_hash_start  <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_found   <= 1'b0;
            r_res_nonce   <= '0;
            r_res_hash    <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_mem_we     <= 1'b0;
            r_hash_start <= 1'b0;
            r_cap_valid  <= 1'b0;
            case (r_state)
                IDLE, LOAD: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= MSG_BASE + 16'(r_word_idx);
                        r_mem_wdata <= i_job_word;
                        if (r_state == IDLE) begin
                            r_target <= i_target;
                        end
                        if (r_word_idx == WIDX_W'(MSG_WORDS - 1)) begin
                            r_word_idx <= '0;
                            r_state    <= START;
                        end else begin
                            r_word_idx <= r_word_idx + 1'b1;
                            r_state    <= LOAD;
                        end
                    end
                end
                // Last header write lands in this cycle, so the hasher is released one cycle later.
                START: begin
                    r_hash_start <= 1'b1;
                    r_mem_sel    <= 1'b0;
                    r_wd         <= '0;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (i_hash_done) begin
                        r_mem_sel  <= 1'b1;
                        r_mem_addr <= OUT_BASE;
                        r_rd_idx   <= '0;
                        r_state    <= READ;
                    end else if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        r_mem_sel     <= 1'b1;
                        r_res_valid   <= 1'b1;
                        r_res_timeout <= 1'b1;
                        r_res_found   <= 1'b0;
                        r_res_nonce   <= '0;
                        r_res_hash    <= HASH_MAX;
                        r_state       <= REPORT;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                // Issue index r; its data is captured by the tracker one cycle later.
                READ: begin
                    if (r_rd_idx < (IDX_W + 1)'(NUM_NONCE)) begin
                        r_cap_valid <= 1'b1;
                        r_cap_idx   <= r_rd_idx[IDX_W-1:0];
                        r_rd_idx    <= r_rd_idx + 1'b1;
                        if (r_rd_idx < (IDX_W + 1)'(NUM_NONCE - 1)) begin
                            r_mem_addr <= r_mem_addr + 16'd1;
                        end
                    end else begin
                        r_res_valid   <= 1'b1;
                        r_res_timeout <= 1'b0;
                        r_res_found   <= (w_min_hash < r_target);
                        r_res_nonce   <= w_min_index;
                        r_res_hash    <= w_min_hash;
                        r_state       <= REPORT;
                    end
                end
                REPORT: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
